// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller sitting in front of the CP0 exception block.
//
// Synchronises N_SRC asynchronous interrupt lines. It detects a rising edge or
// tracks the level of each source, depending on MODE. It keeps pending requests,
// applies the MASK, and selects the lowest-index eligible source. The result is
// presented to CP0 as a single request line with an id. An ack/eoi handshake
// keeps only one interrupt in service at a time.
//
// Ports:
//   clk       main clock
//   rst_n     asynchronous active-low reset
//   irq_src   raw asynchronous interrupt lines, active-high
//   wr_en     register write strobe
//   wr_addr   register write address (0 MASK, 1 MODE, 2 PENDING, 3 STATUS)
//   wr_data   register write data
//   rd_addr   register read address
//   rd_data   registered read data, one cycle after rd_addr
//   irq_req   interrupt request into CP0 ir_in
//   irq_id    id of the requesting source, valid while irq_req is high
//   irq_ack   one-cycle pulse, CP0 has taken the interrupt
//   irq_eoi   one-cycle pulse, handler finished
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic [1:0]       rd_addr,
    output logic [31:0]      rd_data,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    input  logic             irq_eoi
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    logic [N_SRC-1:0]  sync_1;
    logic [N_SRC-1:0]  sync_2;
    logic [N_SRC-1:0]  prev;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC-1:0]  mode_q;
    logic [N_SRC-1:0]  pend_q;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  pend_view;
    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  w1c;
    logic [N_SRC-1:0]  ack_clr;
    logic [N_SRC-1:0]  pend_next;
    logic [ID_W-1:0]   top_id;
    logic [ID_W-1:0]   isr_id;
    logic              any_elig;
    logic              ack_take;
    logic              req_next;
    logic [31:0]       rd_next;

    // Write-data bits above the implemented sources have no storage behind them.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data[31:N_SRC];

    assign rise     = sync_2 & ~prev;
    // Level-mode sources are never stored: they read the synchronised line directly.
    assign pend_view = (pend_q & mode_q) | (sync_2 & ~mode_q);
    assign eligible  = pend_view & mask_q;
    assign any_elig  = |eligible;
    assign ack_take  = (state == REQ) && irq_ack;
    assign w1c       = (wr_en && (wr_addr == 2'd2)) ? wr_data[N_SRC-1:0] : '0;
    // A fresh edge wins over a W1C or ack clear landing in the same cycle.
    assign pend_next = (rise | (pend_q & ~w1c & ~ack_clr)) & mode_q;
    // Request is withdrawn as soon as nothing is eligible or CP0 has acked it.
    assign req_next  = (state == REQ) && any_elig && !irq_ack;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        top_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                top_id = ID_W'(i);
            end
        end
    end

    // The ack clears the source CP0 saw on irq_id, not whatever is best right now.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = ack_take && (irq_id == ID_W'(i));
        end
    end

    // Two-flop synchroniser, plus one more stage to detect rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            prev   <= '0;
        end else begin
            sync_1 <= irq_src;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    // Software-visible MASK/MODE registers and the stored edge-pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
        end else begin
            if (wr_en && (wr_addr == 2'd0)) begin
                mask_q <= wr_data[N_SRC-1:0];
            end
            if (wr_en && (wr_addr == 2'd1)) begin
                mode_q <= wr_data[N_SRC-1:0];
            end
            pend_q <= pend_next;
        end
    end

    // Request/service handshake. The outputs are registered, so irq_req lags
    // entry into REQ by one cycle. Ack takes precedence over eligibility
    // vanishing, because CP0 has already seen irq_req high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
            isr_id  <= '0;
        end else begin
            irq_req <= req_next;
            if (req_next) begin
                irq_id <= top_id;
            end
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state  <= SERVICE;
                        isr_id <= irq_id;
                    end else if (!any_elig) begin
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (irq_eoi) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux. A write in the same cycle is not yet visible here.
    always_comb begin
        rd_next = '0;
        case (rd_addr)
            2'd0: rd_next[N_SRC-1:0] = mask_q;
            2'd1: rd_next[N_SRC-1:0] = mode_q;
            2'd2: rd_next[N_SRC-1:0] = pend_view;
            default: begin
                rd_next[1:0]      = state;
                rd_next[ID_W+7:8] = isr_id;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: self-checking bench for irq_ctrl.
// A behavioural model, stepped once per clock by the stimulus process, predicts
// irq_req, irq_id and rd_data. A compare process checks every negedge. Directed
// scenarios add literal expectations, and a randomized phase follows.
module tb_irq_ctrl;

    localparam int N_SRC = 8;
    localparam int ID_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_SRC-1:0] irq_src;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [1:0]       rd_addr;
    logic [31:0]      rd_data;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;
    logic             irq_eoi;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state. hist0 is the newest sample of irq_src.
    logic [N_SRC-1:0] m_mask, m_mode, m_pend_e, hist0, hist1, hist2;
    int               m_state;
    logic             m_req;
    logic [ID_W-1:0]  m_id;
    logic [ID_W-1:0]  m_isr;
    logic [31:0]      m_rd;

    irq_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .irq_ack (irq_ack),
        .irq_eoi (irq_eoi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mask = '0; m_mode = '0; m_pend_e = '0;
        hist0 = '0; hist1 = '0; hist2 = '0;
        m_state = 0; m_req = 1'b0; m_id = '0; m_isr = '0; m_rd = '0;
    endtask

    // Applies one clock edge of the rules to the model using the pre-edge state.
    task automatic modelStep(input logic [N_SRC-1:0] src, input logic we, input logic [1:0] wa,
                             input logic [31:0] wd, input logic [1:0] ra, input logic ack, input logic eoi);
        logic [N_SRC-1:0] level, edges, view, elig, npend;
        int lowest, nstate;
        logic acked, nreq;
        logic [31:0] rd;
        level  = hist1;
        edges  = hist1 & ~hist2;
        view   = (m_pend_e & m_mode) | (level & ~m_mode);
        elig   = view & m_mask;
        lowest = -1;
        for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) lowest = i;
        case (ra)
            2'd0: rd = 32'(m_mask);
            2'd1: rd = 32'(m_mode);
            2'd2: rd = 32'(view);
            default: rd = (32'(m_isr) << 8) | 32'(m_state);
        endcase
        acked = (m_state == 1) && ack;
        for (int i = 0; i < N_SRC; i++) begin
            if (m_mode[i])
                npend[i] = edges[i] | (m_pend_e[i] && !(we && wa == 2'd2 && wd[i]) && !(acked && int'(m_id) == i));
            else
                npend[i] = 1'b0;
        end
        nstate = m_state;
        if (m_state == 0 && elig != 0) nstate = 1;
        else if (m_state == 1 && ack) nstate = 2;
        else if (m_state == 1 && elig == 0) nstate = 0;
        else if (m_state == 2 && eoi) nstate = 0;
        nreq = (m_state == 1) && (elig != 0) && !ack;
        if (acked) m_isr = m_id;
        if (nreq) m_id = ID_W'(lowest);
        m_req    = nreq;
        m_state  = nstate;
        m_pend_e = npend;
        m_rd     = rd;
        if (we && wa == 2'd0) m_mask = wd[N_SRC-1:0];
        if (we && wa == 2'd1) m_mode = wd[N_SRC-1:0];
        hist2 = hist1; hist1 = hist0; hist0 = src;
    endtask

    // Called at a negedge: drive, take one posedge, step the model, return at the next negedge.
    task automatic applyStimulus(input logic [N_SRC-1:0] src, input logic we, input logic [1:0] wa,
                                 input logic [31:0] wd, input logic [1:0] ra, input logic ack, input logic eoi);
        irq_src = src; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr = ra; irq_ack = ack; irq_eoi = eoi;
        @(posedge clk);
        if (rst_n) modelStep(src, we, wa, wd, ra, ack, eoi);
        @(negedge clk);
    endtask

    task automatic idle(input logic [N_SRC-1:0] src, input logic [1:0] ra);
        applyStimulus(src, 1'b0, 2'd0, 32'd0, ra, 1'b0, 1'b0);
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus('0, 1'b1, a, d, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic ackPulse(input logic [N_SRC-1:0] src);
        applyStimulus(src, 1'b0, 2'd0, 32'd0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic eoiPulse(input logic [N_SRC-1:0] src);
        applyStimulus(src, 1'b0, 2'd0, 32'd0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic waitReq(input logic [N_SRC-1:0] src, input string name);
        int k;
        k = 0;
        while (irq_req !== 1'b1 && k < 20) begin
            idle(src, 2'd0);
            k++;
        end
        checkOutput(name, 32'(irq_req), 32'd1);
    endtask

    // Continuous check of the DUT against the model.
    always @(negedge clk) begin
        checkOutput("cmp_irq_req", 32'(irq_req), 32'(m_req));
        checkOutput("cmp_irq_id",  32'(irq_id),  32'(m_id));
        checkOutput("cmp_rd_data", rd_data, m_rd);
    end

    initial begin
        logic [N_SRC-1:0] rsrc;
        rst_n = 1'b1;
        irq_src = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        modelReset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_req", 32'(irq_req), 32'd0);
        checkOutput("reset_id", 32'(irq_id), 32'd0);
        checkOutput("reset_rd", rd_data, 32'd0);

        // Single edge source through the full handshake.
        writeReg(2'd0, 32'h01);
        writeReg(2'd1, 32'h01);
        idle(8'h01, 2'd2);
        idle(8'h00, 2'd2);
        idle(8'h00, 2'd2);
        idle(8'h00, 2'd2);
        checkOutput("t1_pend_set", rd_data, 32'h1);
        checkOutput("t1_req_not_yet", 32'(irq_req), 32'd0);
        idle(8'h00, 2'd2);
        checkOutput("t1_req", 32'(irq_req), 32'd1);
        checkOutput("t1_id", 32'(irq_id), 32'd0);
        applyStimulus('0, 1'b0, 2'd0, 32'd0, 2'd2, 1'b1, 1'b0);
        idle(8'h00, 2'd2);
        checkOutput("t1_pend_clr", rd_data, 32'h0);
        idle(8'h00, 2'd3);
        checkOutput("t1_status_svc", rd_data, 32'h2);
        applyStimulus('0, 1'b0, 2'd0, 32'd0, 2'd3, 1'b0, 1'b1);
        idle(8'h00, 2'd3);
        checkOutput("t1_status_idle", rd_data, 32'h0);
        idle(8'h00, 2'd3);
        checkOutput("t1_no_req", 32'(irq_req), 32'd0);

        // Simultaneous edges on 5 and 2: lowest index first.
        writeReg(2'd0, 32'hFF);
        writeReg(2'd1, 32'hFF);
        idle(8'h24, 2'd0);
        waitReq(8'h00, "t2_req_a");
        checkOutput("t2_id_first", 32'(irq_id), 32'd2);
        ackPulse(8'h00);
        idle(8'h00, 2'd0);
        eoiPulse(8'h00);
        waitReq(8'h00, "t2_req_b");
        checkOutput("t2_id_second", 32'(irq_id), 32'd5);
        ackPulse(8'h00);
        eoiPulse(8'h00);

        // Level source held through ack/eoi re-requests.
        writeReg(2'd1, 32'h00);
        writeReg(2'd0, 32'h08);
        waitReq(8'h08, "t3_req");
        checkOutput("t3_id", 32'(irq_id), 32'd3);
        ackPulse(8'h08);
        idle(8'h08, 2'd0);
        eoiPulse(8'h08);
        waitReq(8'h08, "t3_rereq");
        checkOutput("t3_id_again", 32'(irq_id), 32'd3);
        ackPulse(8'h08);
        repeat (4) idle(8'h00, 2'd0);
        eoiPulse(8'h00);
        repeat (4) idle(8'h00, 2'd3);
        checkOutput("t3_no_req", 32'(irq_req), 32'd0);
        checkOutput("t3_state_idle", 32'(rd_data[1:0]), 32'd0);

        // Masking a requesting source withdraws the request.
        writeReg(2'd1, 32'h10);
        writeReg(2'd0, 32'h10);
        idle(8'h10, 2'd0);
        waitReq(8'h00, "t4_req");
        checkOutput("t4_id", 32'(irq_id), 32'd4);
        applyStimulus('0, 1'b1, 2'd0, 32'h0, 2'd2, 1'b0, 1'b0);
        idle(8'h00, 2'd2);
        checkOutput("t4_req_drop", 32'(irq_req), 32'd0);
        checkOutput("t4_pend_kept", rd_data, 32'h10);
        idle(8'h00, 2'd3);
        checkOutput("t4_state_idle", 32'(rd_data[1:0]), 32'd0);
        writeReg(2'd2, 32'h10);

        // Edge and W1C in the same cycle: set wins.
        writeReg(2'd1, 32'h02);
        idle(8'h02, 2'd0);
        idle(8'h00, 2'd0);
        applyStimulus('0, 1'b1, 2'd2, 32'h02, 2'd0, 1'b0, 1'b0);
        idle(8'h00, 2'd2);
        checkOutput("t5_set_wins", rd_data, 32'h02);
        writeReg(2'd2, 32'h02);
        idle(8'h00, 2'd2);
        checkOutput("t5_w1c", rd_data, 32'h00);

        // Asynchronous reset while in service with pending work.
        writeReg(2'd1, 32'h0F);
        writeReg(2'd0, 32'h0F);
        idle(8'h0F, 2'd0);
        waitReq(8'h00, "t6_req");
        ackPulse(8'h00);
        idle(8'h01, 2'd0);
        idle(8'h00, 2'd0);
        idle(8'h00, 2'd0);
        idle(8'h00, 2'd2);
        checkOutput("t6_pend", rd_data, 32'h0F);
        idle(8'h00, 2'd3);
        checkOutput("t6_svc", rd_data, 32'h2);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("t6_async_req", 32'(irq_req), 32'd0);
        checkOutput("t6_async_rd", rd_data, 32'd0);
        checkOutput("t6_async_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            idle(8'h00, 2'(a));
            checkOutput("t6_reg_zero", rd_data, 32'd0);
        end
        repeat (8) idle(8'h00, 2'd0);
        checkOutput("t6_no_req", 32'(irq_req), 32'd0);

        // Randomized traffic against the model.
        rsrc = '0;
        for (int c = 0; c < 3000; c++) begin
            rsrc = rsrc ^ (N_SRC'($urandom) & N_SRC'($urandom) & N_SRC'($urandom));
            applyStimulus(rsrc, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), $urandom,
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- External interrupt controller that sits directly upstream of the CP0 exception block.
- Synchronises N asynchronous interrupt lines and detects edges or levels per source.
- Latches pending requests, applies a software mask and picks the highest-priority source.
- Drives a single request line into CP0's ir_in, with an acknowledge/end-of-interrupt handshake so only one interrupt is in service at a time.

Parameters:
- N_SRC, 8, number of external interrupt sources (1..16).
- ID_W, 4, width of the source-id field (must satisfy 2^ID_W >= N_SRC).

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous, active-low reset.
- irq_src  in  N_SRC  raw asynchronous interrupt lines, active-high.
- wr_en  in  1  register write strobe.
- wr_addr  in  2  register write address.
- wr_data  in  32  register write data.
- rd_addr  in  2  register read address.
- rd_data  out  32  registered read data.
- irq_req  out  1  interrupt request; connects to CP0 ir_in.
- irq_id  out  ID_W  id of the requesting source; valid while irq_req=1.
- irq_ack  in  1  one-cycle pulse: CP0 has taken the interrupt.
- irq_eoi  in  1  one-cycle pulse: handler finished (ERET).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - MASK=0, MODE=0, PENDING=0, synchroniser and edge flops=0, state=IDLE.
  - irq_req=0, irq_id=0, rd_data=0.
- Input synchronisation:
  - Each irq_src bit passes through a 2-flop synchroniser (sync), then one more flop (prev).
  - A rising edge is sync&~prev.
  - Latency from irq_src rise to PENDING set is 3 clk.
- Register map:
  - 0 = MASK, rw; bit i=1 enables source i.
  - 1 = MODE, rw; bit i=1 means edge mode, 0 means level mode.
  - 2 = PENDING, read; write-1-to-clear, edge-mode bits only.
  - 3 = STATUS, read-only: bits[1:0]=state, bits[ID_W+7:8]=in-service id.
  - Bits at or above N_SRC in MASK/MODE/PENDING read 0 and ignore writes.
- Pending bits:
  - Edge mode: set on a detected edge; cleared by W1C or by irq_ack for the acknowledged id. Set wins over a clear in the same cycle.
  - Level mode: the PENDING bit reads the synchronised level and is never stored.
- Candidate set: eligible = PENDING & MASK. Priority goes to the lowest index.
- Read path: rd_data <= reg[rd_addr] on every clk (1-cycle latency). A write and a read of the same register in the same cycle returns the old value.
- FSM:
  - IDLE (0): if eligible!=0, go to REQ.
  - REQ (1):
    - irq_req=1.
    - irq_id tracks the current highest-priority eligible source every cycle.
    - If eligible becomes 0 (masked or cleared), go to IDLE and drop irq_req on the next cycle.
    - On irq_ack: latch irq_id as the in-service id, clear its PENDING bit if edge mode, go to SERVICE.
  - SERVICE (2):
    - irq_req=0; new edges keep accumulating in PENDING.
    - On irq_eoi, go to IDLE; re-arbitration happens the following cycle.
- Outputs are registered, so irq_req rises 1 clk after the FSM enters REQ.
- irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
- irq_ack and irq_eoi in the same cycle: the ack is processed and eoi is ignored.
- A level-mode source still asserted after eoi re-requests immediately; software clears the device first.
- Reset asserted mid-operation returns everything to reset values immediately. No request survives reset.

Test Plan:
- MASK=0x01, MODE=0x01; pulse irq_src[0] for 1 cycle -> PENDING[0]=1 after 3 clk; irq_req=1, irq_id=0 one cycle later; irq_ack -> PENDING[0]=0, STATUS state=2; irq_eoi -> state=0, irq_req stays 0.
- MASK=0xFF, MODE=0xFF; edges on sources 5 and 2 in the same cycle -> irq_id=2; after ack and eoi -> irq_id=5.
- MODE=0x00, MASK=0x08; hold irq_src[3]=1 through ack and eoi -> irq_req re-asserts after eoi; drop the line -> no request.
- In REQ for source 4, write MASK=0x00 -> irq_req falls within 2 clk, state=IDLE; PENDING[4] still reads 1.
- Edge on source 1 in the same cycle as a W1C write of 0x02 to PENDING -> PENDING[1]=1 (set wins).
- Assert rst_n=0 in SERVICE with PENDING=0x0F -> all registers 0, irq_req=0 without waiting for a clk edge; after release no request occurs.
